wr_stream_ctrl: RTL
===================

WR_STREAM_CTRL -- requirements
Module: wr_stream_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8: payload data width.
REQ-002 SHALL have parameter MAXLEN, default 16: maximum packet length in words; legal range 2..65535.
REQ-003 SHALL have port wclk, input, 1: the single clock, rising-edge active.
REQ-004 SHALL have port wrst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 1: upstream word valid.
REQ-006 SHALL have port s_data, input, DSIZE: upstream word.
REQ-007 SHALL have port s_last, input, 1: final word of the packet.
REQ-008 SHALL have port s_ready, output, 1: upstream accept; a transfer occurs when s_valid and s_ready are both high.
REQ-009 SHALL have port wfull, input, 1: FIFO full flag from the write-pointer stage.
REQ-010 SHALL have port afull, input, 1: FIFO almost-full flag from the write-pointer stage.
REQ-011 SHALL have port winc, output, 1: FIFO write enable.
REQ-012 SHALL have port wdata, output, DSIZE+1: FIFO write word {last, data}.
REQ-013 SHALL have port pkt_cnt, output, 16: count of packets written to the FIFO.
REQ-014 SHALL have port drop_cnt, output, 16: count of truncated packets.
REQ-015 SHALL have port err_len, output, 1: one-cycle pulse on each truncation.

Function
REQ-016 SHALL buffer accepted words in a 2-entry in-order skid buffer; wdata SHALL equal the head entry.
REQ-017 SHALL drive winc = buffer non-empty AND NOT wfull; the head entry SHALL pop on the same edge that winc is sampled high.
REQ-018 SHALL apply a simultaneous push and pop in one cycle, leaving occupancy unchanged.
REQ-019 SHALL give a minimum latency of one cycle: a word accepted at edge N is presented with winc high in cycle N+1 when wfull is low.
REQ-020 SHALL implement the FSM states IDLE, BODY and DROP, with reset state IDLE.
REQ-021 SHALL hold a length counter len of 16 bits, cleared on entering IDLE.
REQ-022 SHALL handle an IDLE transfer as follows: push the word; with s_last high, stay in IDLE; with s_last low, go to BODY with len=1.
REQ-023 SHALL handle a BODY transfer as follows: push the word and increment len; with s_last high, go to IDLE.
REQ-024 SHALL, on a BODY transfer with len+1==MAXLEN and s_last low, push the word with last forced to 1, pulse err_len, and go to DROP.
REQ-025 SHALL, on a DROP transfer, discard the word without pushing it; s_last high SHALL return the FSM to IDLE.
REQ-026 SHALL drive s_ready as follows: in DROP, 1; in IDLE, (occupancy<2) AND NOT afull; in BODY, occupancy<2.
REQ-027 SHALL never block a packet in progress on afull; packet starts SHALL be admitted only while afull is low.
REQ-028 SHALL increment pkt_cnt on each push whose stored last bit is 1, and increment drop_cnt on each err_len pulse; both counters SHALL saturate at 16'hFFFF.
REQ-029 SHALL leave the buffer and FIFO words unaffected by s_data/s_last values while s_valid is low.

Reset
REQ-030 SHALL, while wrst is high at a wclk edge, empty the buffer, set the FSM to IDLE, set len=0, and set pkt_cnt=0, drop_cnt=0, err_len=0.
REQ-031 SHALL hold winc=0 and s_ready=0 during reset, and SHALL hold wdata=0 after reset while the buffer is empty.
REQ-032 SHALL, when reset occurs mid-packet, discard buffered words and the partial packet with no completion marker written.

Configuration
REQ-033 SHALL, with macro WR_STREAM_CNT_EN defined, implement the pkt_cnt and drop_cnt registers as specified.
REQ-034 SHALL, without WR_STREAM_CNT_EN, keep the pkt_cnt and drop_cnt ports present but tie them to 0 with no counter flops; err_len and truncation SHALL be unaffected.

Structure
REQ-035 SHALL take the FSM state encoding (IDLE=2'd0, BODY=2'd1, DROP=2'd2) and the counter width constant (16) from the shared package wr_stream_pkg.
REQ-036 SHALL implement the 2-entry buffer as the sub-module wr_skid_buf, with push/pop/occupancy ports and width DSIZE+1.

Verification
REQ-037 SHALL cover a single word, 0x5A, with s_last=1 and the FIFO empty -> next cycle winc=1, wdata=0x15A, and pkt_cnt=1.
REQ-038 SHALL cover a 4-word packet with wfull held high for 3 cycles after the first push -> s_ready drops once occupancy is 2, no word is lost or reordered, and 4 winc pulses occur after wfull falls.
REQ-039 SHALL cover MAXLEN=16 with a 20-word packet -> 16 words written, the 16th with last=1, err_len pulses once, the remaining 4 words are accepted and discarded, and drop_cnt=1, pkt_cnt=1.
REQ-040 SHALL cover afull=1 in IDLE with s_valid=1 -> s_ready=0; with afull=1 mid-BODY -> transfers continue.
REQ-041 SHALL cover wrst asserted after word 2 of a 5-word packet -> the next cycle has winc=0, occupancy 0, state IDLE, and counters 0; a fresh packet afterwards is written correctly.
REQ-042 SHALL cover a build without WR_STREAM_CNT_EN driving 3 packets -> pkt_cnt and drop_cnt stay 0 while the data path is identical.

Source files
------------

// File: rtl/wr_stream_pkg.sv
// Shared constants for the packet write-stream controller: FSM encoding and counter width.
// Optional statistics counters are enabled by defining WR_STREAM_CNT_EN.
package wr_stream_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BODY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is the head.
// Latency: one cycle from push to head. Caller must not push when full or pop when empty.
// Backpressure: occupancy is exported so the producer can stop at two entries.
module wr_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = push_dat_i;
                else               e1_d = push_dat_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    e0_d = push_dat_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) occ_q <= 2'd0;
        else       occ_q <= occ_d;
    end

    always_ff @(posedge clk_i) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign head_dat_o = (occ_q != 2'd0) ? e0_q : '0;
    assign occ_o      = occ_q;

endmodule

// File: rtl/wr_stream_ctrl.sv
// Packet write controller: skid-buffers upstream words into a FIFO and truncates packets at MAXLEN.
// Latency: one cycle accept-to-winc. Backpressure: s_ready drops at 2 buffered words; new packets wait on afull.
// Define WR_STREAM_CNT_EN to build the pkt_cnt/drop_cnt statistics registers.
module wr_stream_ctrl
    import wr_stream_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int MAXLEN = 16
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             wfull,
    input  logic             afull,
    output logic             winc,
    output logic [DSIZE:0]   wdata,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_len
);

    localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAXLEN - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_len_q, err_len_d;
    logic [1:0]       occ;
    logic             occ_full;
    logic             xfer;
    logic             push;
    logic             push_last;
    logic [DSIZE:0]   head_dat;

    assign occ_full = (occ == 2'd2);

    // Only packet starts wait on afull, so a packet already in flight always completes.
    always_comb begin
        case (state_q)
            ST_IDLE: s_ready = !occ_full && !afull;
            ST_BODY: s_ready = !occ_full;
            ST_DROP: s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
        if (wrst) s_ready = 1'b0;
    end

    assign xfer = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        err_len_d = 1'b0;
        push      = 1'b0;
        push_last = s_last;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    push = 1'b1;
                    if (!s_last) begin
                        state_d = ST_BODY;
                        len_d   = 16'd1;
                    end
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    push  = 1'b1;
                    len_d = len_q + 16'd1;
                    if (s_last) begin
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end else if (len_q == LEN_LAST) begin
                        // Close the packet in the FIFO and swallow the rest of it.
                        push_last = 1'b1;
                        err_len_d = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (xfer && s_last) begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                len_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            err_len_q <= err_len_d;
        end
    end

    wr_skid_buf #(
        .W(DSIZE + 1)
    ) u_buf (
        .clk_i     (wclk),
        .rst_i     (wrst),
        .push_i    (push),
        .push_dat_i({push_last, s_data}),
        .pop_i     (winc),
        .head_dat_o(head_dat),
        .occ_o     (occ)
    );

    assign winc    = !wrst && (occ != 2'd0) && !wfull;
    assign wdata   = head_dat;
    assign err_len = err_len_q;

`ifdef WR_STREAM_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && push_last) pkt_cnt_q <= sat_inc(pkt_cnt_q);
            if (err_len_d)         drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule
